// File: rtl/nvdla_cmac_feed_seq_if.sv
// Handshake and framing bundle between the CBUF read side, the feed
// sequencer and the CMAC input port. The sequencer takes the slave view.
interface nvdla_cmac_feed_seq_if #(
  parameter int ATOMK_HALF = 8,
  parameter int CNT_W      = 13
);
  logic                  cfg_start;
  logic [CNT_W-1:0]      cfg_grp_num_m1;
  logic [CNT_W-1:0]      cfg_stripe_num_m1;
  logic [CNT_W-1:0]      cfg_stripe_len_m1;
  logic                  wt_src_vld;
  logic                  wt_src_rdy;
  logic                  dat_src_vld;
  logic                  dat_src_rdy;
  logic                  sc2mac_wt_pvld;
  logic [ATOMK_HALF-1:0] sc2mac_wt_sel;
  logic                  sc2mac_dat_pvld;
  logic [8:0]            sc2mac_dat_pd;
  logic                  busy;
  logic                  done;

  modport master (
    output cfg_start, cfg_grp_num_m1, cfg_stripe_num_m1, cfg_stripe_len_m1,
    output wt_src_vld, dat_src_vld,
    input  wt_src_rdy, dat_src_rdy,
    input  sc2mac_wt_pvld, sc2mac_wt_sel, sc2mac_dat_pvld, sc2mac_dat_pd,
    input  busy, done
  );

  modport slave (
    input  cfg_start, cfg_grp_num_m1, cfg_stripe_num_m1, cfg_stripe_len_m1,
    input  wt_src_vld, dat_src_vld,
    output wt_src_rdy, dat_src_rdy,
    output sc2mac_wt_pvld, sc2mac_wt_sel, sc2mac_dat_pvld, sc2mac_dat_pd,
    output busy, done
  );
endinterface

// File: rtl/nvdla_cmac_feed_seq.sv
// CMAC feed sequencer: loads one kernel group of weights (one beat per MAC
// cell, one-hot select walk), then streams framed feature-data atomics.
// The CMAC cannot stall, so every pvld pulse is the registered image of one
// source accept from the previous cycle.
//
// state | meaning
// IDLE  | waiting for cfg_start, all outputs low
// WT    | pulling weight beats, one per MAC cell
// DAT   | pulling data atomics for all stripes of the current group
// FIN   | last data beat on the CMAC bus; done/busy update on exit
module nvdla_cmac_feed_seq #(
  parameter int ATOMK_HALF = 8,
  parameter int CNT_W      = 13
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  nvdla_cmac_feed_seq_if.slave    io
);

  localparam int WT_W = (ATOMK_HALF > 1) ? $clog2(ATOMK_HALF) : 1;
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(ATOMK_HALF - 1);
  localparam logic [ATOMK_HALF-1:0] SEL_ONE = {{(ATOMK_HALF-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WT, DAT, FIN} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      grp_num_q;
  logic [CNT_W-1:0]      stripe_num_q;
  logic [CNT_W-1:0]      stripe_len_q;
  logic [WT_W-1:0]       wt_cnt_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic [CNT_W-1:0]      stripe_cnt_q;
  logic [CNT_W-1:0]      grp_cnt_q;
  logic                  wt_rdy_q;
  logic                  dat_rdy_q;
  logic                  wt_pvld_q;
  logic [ATOMK_HALF-1:0] wt_sel_q;
  logic                  dat_pvld_q;
  logic [8:0]            dat_pd_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  stripe_end_d;
  logic                  channel_end_d;
  logic                  layer_end_d;
  logic [8:0]            dat_pd_d;

  // Framing of the atomic about to be accepted, from the current counters.
  always_comb begin
    stripe_end_d  = (beat_cnt_q == stripe_len_q);
    channel_end_d = stripe_end_d && (stripe_cnt_q == stripe_num_q);
    layer_end_d   = channel_end_d && (grp_cnt_q == grp_num_q);
    dat_pd_d      = {5'b0, layer_end_d, channel_end_d, stripe_end_d, (beat_cnt_q == '0)};
  end

  // Sequencer FSM with all outputs registered; pvld/sel/pd default low each cycle.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= IDLE;
      grp_num_q    <= '0;
      stripe_num_q <= '0;
      stripe_len_q <= '0;
      wt_cnt_q     <= '0;
      beat_cnt_q   <= '0;
      stripe_cnt_q <= '0;
      grp_cnt_q    <= '0;
      wt_rdy_q     <= 1'b0;
      dat_rdy_q    <= 1'b0;
      wt_pvld_q    <= 1'b0;
      wt_sel_q     <= '0;
      dat_pvld_q   <= 1'b0;
      dat_pd_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wt_pvld_q  <= 1'b0;
      wt_sel_q   <= '0;
      dat_pvld_q <= 1'b0;
      dat_pd_q   <= '0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io.cfg_start) begin
            grp_num_q    <= io.cfg_grp_num_m1;
            stripe_num_q <= io.cfg_stripe_num_m1;
            stripe_len_q <= io.cfg_stripe_len_m1;
            wt_cnt_q     <= '0;
            beat_cnt_q   <= '0;
            stripe_cnt_q <= '0;
            grp_cnt_q    <= '0;
            busy_q       <= 1'b1;
            wt_rdy_q     <= 1'b1;
            state_q      <= WT;
          end
        end
        WT: begin
          if (io.wt_src_vld && wt_rdy_q) begin
            wt_pvld_q <= 1'b1;
            wt_sel_q  <= SEL_ONE << wt_cnt_q;
            if (wt_cnt_q == WT_LAST) begin
              wt_cnt_q  <= '0;
              wt_rdy_q  <= 1'b0;
              dat_rdy_q <= 1'b1;
              state_q   <= DAT;
            end else begin
              wt_cnt_q <= wt_cnt_q + 1'b1;
            end
          end
        end
        DAT: begin
          if (io.dat_src_vld && dat_rdy_q) begin
            dat_pvld_q <= 1'b1;
            dat_pd_q   <= dat_pd_d;
            if (stripe_end_d) begin
              beat_cnt_q <= '0;
              if (channel_end_d) begin
                stripe_cnt_q <= '0;
                dat_rdy_q    <= 1'b0;
                if (layer_end_d) begin
                  grp_cnt_q <= '0;
                  state_q   <= FIN;
                end else begin
                  grp_cnt_q <= grp_cnt_q + 1'b1;
                  wt_rdy_q  <= 1'b1;
                  state_q   <= WT;
                end
              end else begin
                stripe_cnt_q <= stripe_cnt_q + 1'b1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.wt_src_rdy      = wt_rdy_q;
  assign io.dat_src_rdy     = dat_rdy_q;
  assign io.sc2mac_wt_pvld  = wt_pvld_q;
  assign io.sc2mac_wt_sel   = wt_sel_q;
  assign io.sc2mac_dat_pvld = dat_pvld_q;
  assign io.sc2mac_dat_pd   = dat_pd_q;
  assign io.busy            = busy_q;
  assign io.done            = done_q;

endmodule

// File: doc/nvdla_cmac_feed_seq.md
Name: nvdla_cmac_feed_seq

Overview:
- Sequencer between the CBUF read side and the CMAC input port.
- Drives the weight-load phase: one-hot sc2mac_wt_sel walk, one kernel per beat, loading each MAC cell.
- Then streams feature-data atomics with stripe/channel/layer framing on sc2mac_dat_pd.
- The CMAC has no backpressure, so this block is the only flow-control point: it pulls from ready/valid sources and issues valid-only pulses.

Parameters:
ATOMK_HALF, 8, number of MAC cells; width of wt_sel and number of weight beats per kernel group
CNT_W, 13, width of all configuration counters

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- cfg_start  in  1  single-cycle start pulse; ignored while busy=1
- cfg_grp_num_m1  in  CNT_W  kernel groups minus 1
- cfg_stripe_num_m1  in  CNT_W  stripes per group minus 1
- cfg_stripe_len_m1  in  CNT_W  data atomics per stripe minus 1
- wt_src_vld  in  1  weight beat available
- wt_src_rdy  out  1  weight beat accepted
- dat_src_vld  in  1  data atomic available
- dat_src_rdy  out  1  data atomic accepted
- sc2mac_wt_pvld  out  1  weight beat valid to CMAC
- sc2mac_wt_sel  out  ATOMK_HALF  one-hot destination MAC cell
- sc2mac_dat_pvld  out  1  data valid to CMAC
- sc2mac_dat_pd  out  9  framing: [0] stripe_st, [1] stripe_end, [2] channel_end, [3] layer_end, [8:4] zero
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  single-cycle pulse after the final data beat is issued

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all counters 0. Every output is 0: rdy, pvld, wt_sel, dat_pd, busy, done.
- Config is latched on accepted cfg_start (start seen in IDLE). Config is not sampled again until the next start.
- FSM states: IDLE, WT, DAT, FIN.
- IDLE -> WT on cfg_start; busy=1 next cycle.
- WT:
  - wt_src_rdy=1, dat_src_rdy=0.
  - Each accepted beat (vld&rdy) increments wt_cnt 0..ATOMK_HALF-1.
  - Next cycle: sc2mac_wt_pvld=1, sc2mac_wt_sel=1<<wt_cnt(at accept).
  - After beat ATOMK_HALF-1 is accepted -> DAT, wt_cnt cleared.
- DAT:
  - dat_src_rdy=1, wt_src_rdy=0.
  - Each accepted beat increments beat_cnt. At beat_cnt==stripe_len_m1, beat_cnt wraps to 0 and stripe_cnt increments.
  - Framing is registered with the data, 1-cycle latency:
    - stripe_st = (beat_cnt==0)
    - stripe_end = (beat_cnt==stripe_len_m1)
    - channel_end = stripe_end & (stripe_cnt==stripe_num_m1)
    - layer_end = channel_end & (grp_cnt==grp_num_m1)
  - stripe_len_m1=0: stripe_st and stripe_end are both 1 on every beat.
  - After the channel_end beat is accepted: if layer_end -> FIN; else grp_cnt++, stripe_cnt=0 -> WT.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, -> IDLE.
- Output timing:
  - sc2mac_*_pvld low in cycles with no accepted beat, and never high in the same cycle as each other.
  - wt_sel and dat_pd are 0 whenever the corresponding pvld is 0.
- Source vld with rdy low: no effect; the source holds. Bubbles on either source only stall; counters do not move.
- Phase changes take 0 idle cycles. The cycle after the last weight accept already presents dat_src_rdy=1, and vice versa.
- cfg_start while busy or in FIN: ignored, no state change.
- Counters are CNT_W bits and wrap only via the compares above; all-ones config values are legal (2^CNT_W iterations).
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse. A partially loaded weight set is abandoned.

Test Plan:
- grp=0, stripe_num_m1=1, stripe_len_m1=2, both sources always valid:
  - wt_sel 0x01,0x02,...,0x80 on 8 consecutive cycles.
  - Then 6 data beats, pd = 0x1,0x0,0x2,0x1,0x0,0xE.
  - done 1 cycle after the last beat; total 14 pvld cycles.
- grp_num_m1=1, stripe_num_m1=0, stripe_len_m1=0:
  - 8 wt, 1 dat (pd=0x7), 8 wt, 1 dat (pd=0xF).
  - No idle cycle between phases.
- Random bubbles on wt_src_vld/dat_src_vld (50%), same config as first test:
  - Identical pvld/sel/pd sequence with gaps.
  - pvld never high without a preceding accept.
- cfg_start pulsed during DAT and again during FIN: busy unaffected, single done, config unchanged.
- Assert nvdla_core_rstn after 3 weight beats:
  - All outputs 0 in the same cycle, no done.
  - A new start after release re-sequences wt_sel from 0x01.
- cfg_stripe_len_m1 all-ones with CNT_W=4: 16 beats per stripe; stripe_end only on beat 16, correct wrap to 0.
